fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side adapter that sits directly downstream of the async FIFO in the `rd_clk` domain. It pulls words from the FIFO's `rd_en`/`empty`/`rd_data` port, absorbing the RAM's one-cycle read latency, and presents them as a `valid`/`ready` stream to consumers. It uses a 3-entry prefetch buffer, so it sustains one word per cycle with no combinational path from `out_ready` to `fifo_rd_en`. A synchronous flush discards buffered and in-flight data.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data.
- `rd_clk`  in  1  read-domain clock; all logic is on the rising edge.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag (`rd_clk` domain).
- `fifo_rd_en`  out  1  FIFO pop request.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after a sampled `fifo_rd_en`.
- `flush`  in  1  synchronous discard of all buffered and in-flight data.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  DATA_WIDTH  stream data (buffer head).
- `buf_count`  out  2  number of words held in the buffer (0..3).

## Operation
- **State**
  - 3-entry circular buffer: `wptr`/`rptr` each 2 bits, wrapping 2→0.
  - `count` 0..3.
  - `inflight` flag: a read was issued last cycle and its data arrives this cycle.
- **Issue rule (combinational)**
  - `fifo_rd_en = !rd_rst && !flush && !fifo_empty && (count + inflight) < 3`.
  - This depends only on registered state plus `fifo_empty`/`flush`, never on `out_ready`.
- **Capture**
  - If `inflight && !flush`: `fifo_rd_data` is written to `buf[wptr]` at the edge and `wptr` advances.
  - `inflight` ← `fifo_rd_en` every cycle.
- **Pop**
  - `out_valid = (count != 0)`; `out_data = buf[rptr]`.
  - When `out_valid && out_ready`, `rptr` advances.
- **Count**
  - `count` ← `count + push − pop`.
  - Simultaneous push and pop leaves `count` unchanged.
- **Invariant:** `count + inflight ≤ 3`. Buffer overflow is therefore impossible, and no word is read without space reserved for it.
- **Ordering:** words leave in exact FIFO order; none are duplicated or dropped except by `flush`.
- **Empty FIFO:** `fifo_rd_en` is never asserted while `fifo_empty=1`, so the FIFO's underflow flag can never be raised by this block.
- **Flush (cycle F)**
  - `fifo_rd_en=0` in F.
  - At the edge: `count`, `wptr`, `rptr` ← 0 and `inflight` ← 0.
  - Data arriving in F (read issued in F−1) is discarded.
  - A handshake completing in F counts as delivered.
  - `out_valid=0` from F+1.
  - Normal issue resumes in F+1.
- **Reset:** `rd_rst` may assert at any time, including mid-transfer. All state clears immediately (asynchronously) and in-flight data is lost.

## Timing
- **Reset values:** `fifo_rd_en=0`, `out_valid=0`, `out_data=0` (all buffer entries reset to 0), `buf_count=0`, `inflight=0`.
- **First-word latency** (buffer empty, `fifo_empty` falls in cycle N):
  - `fifo_rd_en=1` in N.
  - Data is captured at the end of N+1.
  - `out_valid=1` in N+2.
- **Throughput:** with `out_ready=1` and the FIFO non-empty, one word per cycle; steady state is `count=1`, `inflight=1`.
- **Backpressure:** with `out_ready` held low, exactly 3 reads are issued; `buf_count` saturates at 3 and `fifo_rd_en` stays 0.
- **Release:** when `out_ready` rises with `count=3`, the first pop occurs that cycle and a new read is issued the next cycle.
- **Combinational paths:**
  - `fifo_rd_en` depends on `fifo_empty`, `flush`, `rd_rst` and registers only.
  - `out_valid`, `out_data` and `buf_count` are register-only.

## Test plan
- **Reset:** assert `rd_rst` mid-stream with `count=2` → `out_valid`, `fifo_rd_en` and `buf_count` go to 0 without waiting for a clock edge. After release, the first word out is the next FIFO entry.
- **Single word:** FIFO holds 0xA5, `out_ready=1` → `fifo_rd_en` high for exactly 1 cycle; `out_valid` high 2 cycles later for 1 cycle with `out_data=0xA5`; `buf_count` returns to 0.
- **Streaming:** 16 words 0x00..0x0F, `out_ready=1` → after 2-cycle latency, 16 consecutive `out_valid` cycles with no gaps, in order.
- **Backpressure:** 8 words queued, `out_ready=0` → exactly 3 `fifo_rd_en` pulses, `buf_count=3`, `out_data=0x00` held stable. Release `out_ready` → 0x00..0x07 in order, none lost.
- **Random traffic:** random `out_ready` (50%) with FIFO intermittently empty, 1000 words → scoreboard matches. Assertions: never `fifo_rd_en && fifo_empty`; `count + inflight ≤ 3` always.
- **Flush with in-flight read:** FIFO holds 0x10..0x14; assert `flush` the cycle after the first `fifo_rd_en` → 0x10 is dropped and `buf_count=0` in F+1. The next output word is the next unread FIFO entry, and no stale data appears.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side prefetch adapter: turns the async FIFO's rd_en/empty/rd_data port
// into a valid/ready stream, hiding the RAM's one-cycle read latency.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            buf_count
);

    logic [DATA_WIDTH-1:0] mem0, mem1, mem2;
    logic [1:0]            wptr, rptr, count;
    logic                  inflight;
    logic                  push, pop;
    logic [2:0]            occupancy;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when a slot is already reserved for its data
    assign occupancy  = {1'b0, count} + {2'b00, inflight};
    assign fifo_rd_en = !rd_rst && !flush && !fifo_empty
                        && (occupancy < 3'd3);

    assign push      = inflight && !flush;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign buf_count = count;

    always_comb begin
        out_data = mem0;
        case (rptr)
            2'd1:    out_data = mem1;
            2'd2:    out_data = mem2;
            default: out_data = mem0;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            mem0 <= '0;
            mem1 <= '0;
            mem2 <= '0;
        end else if (push) begin
            if (wptr == 2'd0) mem0 <= fifo_rd_data;
            if (wptr == 2'd1) mem1 <= fifo_rd_data;
            if (wptr == 2'd2) mem2 <= fifo_rd_data;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (flush) begin
                count <= 2'd0;
                wptr  <= 2'd0;
                rptr  <= 2'd0;
            end else begin
                if (push) wptr <= wrap_inc(wptr);
                if (pop)  rptr <= wrap_inc(rptr);
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule
